// File: rtl/corr_autoscale_if.sv
// rtl/corr_autoscale_if.sv - frame stream bundle for the correlation auto-scaler
interface corr_autoscale_if #(
    parameter int DIN_WIDTH   = 32,
    parameter int DOUT_WIDTH  = 16,
    parameter int N_CH        = 4,
    parameter int SHIFT_WIDTH = 5
) ();
    logic [N_CH*DIN_WIDTH-1:0]  din;
    logic                       din_valid;
    logic [N_CH*DOUT_WIDTH-1:0] dout;
    logic                       dout_valid;
    logic [SHIFT_WIDTH-1:0]     shift_used;
    logic [N_CH-1:0]            ovf;

    modport master (
        output din, din_valid,
        input  dout, dout_valid, shift_used, ovf
    );

    modport slave (
        input  din, din_valid,
        output dout, dout_valid, shift_used, ovf
    );
endinterface

// File: rtl/corr_autoscale.sv
// rtl/corr_autoscale.sv - block-floating-point shift tracker and saturating repointer
module corr_autoscale #(
    parameter int DIN_WIDTH   = 32,
    parameter int DIN_POINT   = 16,
    parameter int DOUT_WIDTH  = 16,
    parameter int DOUT_POINT  = 15,
    parameter int N_CH        = 4,
    parameter int SHIFT_WIDTH = 5,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    corr_autoscale_if.slave        bus,
    input  logic                   auto_en,
    input  logic [SHIFT_WIDTH-1:0] manual_shift,
    output logic [15:0]            sat_count
);
    localparam int DSH  = DIN_POINT - DOUT_POINT;
    localparam int MAXS = 2**SHIFT_WIDTH - 1;
    localparam int HW   = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic signed [DIN_WIDTH-1:0] OMAX =
        {{(DIN_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [DIN_WIDTH-1:0] OMIN =
        {{(DIN_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    logic [SHIFT_WIDTH-1:0]    c;
    logic [HW-1:0]             hold;
    logic [SHIFT_WIDTH-1:0]    need;
    logic [DIN_WIDTH-1:0]      chan;
    int                        need_max;
    int                        sig_bits;

    logic                      v1;
    logic [N_CH*DIN_WIDTH-1:0] d1;
    logic [SHIFT_WIDTH-1:0]    s1;

    logic signed [DIN_WIDTH-1:0] x;
    logic signed [DIN_WIDTH-1:0] z;
    logic [N_CH*DOUT_WIDTH-1:0]  dout_n;
    logic [N_CH-1:0]             ovf_n;

    // Leading-sign detect on the unshifted frame: a channel needing sig_bits
    // signed bits fits once shifted right by sig_bits - DOUT_WIDTH in total,
    // of which DSH comes for free from the repointing.
    always_comb begin
        need_max = 0;
        sig_bits = 1;
        chan     = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            chan     = bus.din[ch*DIN_WIDTH +: DIN_WIDTH];
            sig_bits = 1;
            for (int i = 0; i < DIN_WIDTH - 1; i++) begin
                if (chan[i] != chan[DIN_WIDTH-1]) begin
                    sig_bits = i + 2;
                end
            end
            if (sig_bits - DOUT_WIDTH - DSH > need_max) begin
                need_max = sig_bits - DOUT_WIDTH - DSH;
            end
        end
        need = (need_max > MAXS) ? SHIFT_WIDTH'(MAXS) : SHIFT_WIDTH'(need_max);
    end

    // Shift tracker: grow immediately, shrink by one only after a full hold period.
    always_ff @(posedge clk) begin
        if (rst) begin
            c    <= '0;
            hold <= '0;
        end else if (!auto_en) begin
            c    <= manual_shift;
            hold <= '0;
        end else if (bus.din_valid) begin
            if (need > c) begin
                c    <= need;
                hold <= '0;
            end else if (need == c) begin
                hold <= '0;
            end else if (hold == HOLD_LAST) begin
                c    <= c - SHIFT_WIDTH'(1);
                hold <= '0;
            end else begin
                hold <= hold + HW'(1);
            end
        end
    end

    // Stage 1: capture the frame together with the shift it must use.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            s1 <= '0;
        end else begin
            v1 <= bus.din_valid;
            if (bus.din_valid) begin
                d1 <= bus.din;
                s1 <= c;
            end
        end
    end

    // Shift, drop the extra fractional bits (floor) and clamp to the output range.
    always_comb begin
        dout_n = '0;
        ovf_n  = '0;
        x      = '0;
        z      = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            x = d1[ch*DIN_WIDTH +: DIN_WIDTH];
            z = (x >>> s1) >>> DSH;
            if (z > OMAX) begin
                dout_n[ch*DOUT_WIDTH +: DOUT_WIDTH] = OMAX[DOUT_WIDTH-1:0];
                ovf_n[ch] = 1'b1;
            end else if (z < OMIN) begin
                dout_n[ch*DOUT_WIDTH +: DOUT_WIDTH] = OMIN[DOUT_WIDTH-1:0];
                ovf_n[ch] = 1'b1;
            end else begin
                dout_n[ch*DOUT_WIDTH +: DOUT_WIDTH] = z[DOUT_WIDTH-1:0];
            end
        end
    end

    // Stage 2: output registers and the saturating overflow-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.ovf        <= '0;
            bus.shift_used <= '0;
            bus.dout_valid <= 1'b0;
            sat_count      <= '0;
        end else begin
            bus.dout_valid <= v1;
            if (v1) begin
                bus.dout       <= dout_n;
                bus.ovf        <= ovf_n;
                bus.shift_used <= s1;
                if ((|ovf_n) && (sat_count != 16'hFFFF)) begin
                    sat_count <= sat_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_corr_autoscale.sv
// tb/tb_corr_autoscale.sv - directed vector bench for corr_autoscale
module tb_corr_autoscale;
    localparam int N_CH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        auto_en;
    logic [4:0]  manual_shift;
    logic [15:0] sat_count;

    int n_pass = 0;
    int n_total = 0;
    int exp_sat = 0;

    corr_autoscale_if bus ();

    corr_autoscale dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .auto_en      (auto_en),
        .manual_shift (manual_shift),
        .sat_count    (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  shift;
        logic [31:0] din;
        logic [15:0] exp_dout;
        logic [3:0]  exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] v, input logic valid);
        bus.din = {N_CH{v}};
        bus.din_valid = valid;
    endtask

    // Isolated frame: drive one cycle, then one more edge so the result is visible.
    task automatic send_frame(input logic [31:0] v);
        drive(v, 1'b1);
        step();
        drive(32'h0, 1'b0);
        step();
    endtask

    task automatic chk_frame(input string name, input logic [15:0] ed, input logic [3:0] eo,
                             input logic [4:0] es);
        chk({name, ".valid"}, 64'(bus.dout_valid), 64'(1));
        chk({name, ".dout"}, 64'(bus.dout), 64'({N_CH{ed}}));
        chk({name, ".ovf"}, 64'(bus.ovf), 64'(eo));
        chk({name, ".shift"}, 64'(bus.shift_used), 64'(es));
    endtask

    logic [4:0]  exp_s [12];
    logic [15:0] exp_d [12];

    initial begin
        vecs[0] = '{5'd0,  32'h0000_8000, 16'h4000, 4'h0};
        vecs[1] = '{5'd0,  32'h0002_0000, 16'h7FFF, 4'hF};
        vecs[2] = '{5'd2,  32'h0002_0000, 16'h4000, 4'h0};
        vecs[3] = '{5'd0,  32'hFFFE_0000, 16'h8000, 4'hF};
        vecs[4] = '{5'd1,  32'hFFFE_0000, 16'h8000, 4'h0};
        vecs[5] = '{5'd0,  32'h0000_0001, 16'h0000, 4'h0};
        vecs[6] = '{5'd0,  32'hFFFF_FFFF, 16'hFFFF, 4'h0};
        vecs[7] = '{5'd4,  32'h0012_3456, 16'h7FFF, 4'hF};
        vecs[8] = '{5'd5,  32'h0012_3456, 16'h48D1, 4'h0};
        vecs[9] = '{5'd31, 32'h8000_0000, 16'hFFFF, 4'h0};

        rst = 1'b1;
        auto_en = 1'b0;
        manual_shift = 5'd0;
        drive(32'h0, 1'b0);
        step();
        step();
        chk("reset.valid", 64'(bus.dout_valid), 64'(0));
        chk("reset.dout", 64'(bus.dout), 64'(0));
        chk("reset.sat", 64'(sat_count), 64'(0));
        rst = 1'b0;
        step();

        // Manual-shift vector table.
        for (int i = 0; i < 10; i++) begin
            auto_en = 1'b0;
            manual_shift = vecs[i].shift;
            step();
            send_frame(vecs[i].din);
            chk_frame($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_ovf, vecs[i].shift);
            if (vecs[i].exp_ovf != 4'h0) exp_sat++;
            chk($sformatf("vec%0d.sat", i), 64'(sat_count), 64'(exp_sat));
        end

        // Mixed channels: 2.0, 0.5, -2.0, 0 at shift 0.
        manual_shift = 5'd0;
        step();
        bus.din = {32'h0000_0000, 32'hFFFE_0000, 32'h0000_8000, 32'h0002_0000};
        bus.din_valid = 1'b1;
        step();
        drive(32'h0, 1'b0);
        step();
        chk("mixed.dout", 64'(bus.dout), 64'({16'h0000, 16'h8000, 16'h4000, 16'h7FFF}));
        chk("mixed.ovf", 64'(bus.ovf), 64'(4'b0101));

        // Auto from c=0: 2.0 saturates, next 2.0 tracked to shift 2.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_sat = 0;
        manual_shift = 5'd0;
        step();
        auto_en = 1'b1;
        send_frame(32'h0002_0000);
        chk_frame("auto1", 16'h7FFF, 4'hF, 5'd0);
        chk("auto1.sat", 64'(sat_count), 64'(1));
        send_frame(32'h0002_0000);
        chk_frame("auto2", 16'h4000, 4'h0, 5'd2);

        // Back-to-back 0.25 frames: decay 2 -> 1 -> 0 and stay at 0.
        for (int i = 0; i < 12; i++) begin
            exp_s[i] = (i < 4) ? 5'd2 : (i < 8) ? 5'd1 : 5'd0;
            exp_d[i] = (i < 4) ? 16'h0800 : (i < 8) ? 16'h1000 : 16'h2000;
        end
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) drive(32'h0000_4000, 1'b1);
            else drive(32'h0, 1'b0);
            step();
            if (i >= 1) begin
                chk($sformatf("decay%0d.valid", i-1), 64'(bus.dout_valid), 64'(1));
                chk($sformatf("decay%0d.shift", i-1), 64'(bus.shift_used), 64'(exp_s[i-1]));
                chk($sformatf("decay%0d.dout", i-1), 64'(bus.dout[15:0]), 64'(exp_d[i-1]));
            end
        end

        // Start tracking from manual 2, alternate need 1 / need 2: c holds at 2.
        auto_en = 1'b0;
        manual_shift = 5'd2;
        step();
        auto_en = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive((i % 2 == 0) ? 32'h0001_0000 : 32'h0002_0000, 1'b1);
            else drive(32'h0, 1'b0);
            step();
            if (i >= 1) begin
                chk($sformatf("alt%0d.shift", i-1), 64'(bus.shift_used), 64'(2));
                chk($sformatf("alt%0d.dout", i-1), 64'(bus.dout[15:0]),
                    64'(((i-1) % 2 == 0) ? 16'h2000 : 16'h4000));
            end
        end

        // Idle cycles between low frames must not count toward the hold period.
        for (int i = 0; i < 3; i++) send_frame(32'h0000_4000);
        repeat (5) step();
        send_frame(32'h0000_4000);
        chk("idle.frame4.shift", 64'(bus.shift_used), 64'(2));
        send_frame(32'h0000_4000);
        chk("idle.frame5.shift", 64'(bus.shift_used), 64'(1));

        // -2.0 in auto at c=0 saturates to the minimum code.
        auto_en = 1'b0;
        manual_shift = 5'd0;
        step();
        auto_en = 1'b1;
        send_frame(32'hFFFE_0000);
        chk_frame("neg2", 16'h8000, 4'hF, 5'd0);

        // Reset in the middle of a continuous stream.
        drive(32'h0002_0000, 1'b1);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst.valid", 64'(bus.dout_valid), 64'(0));
        chk("midrst.dout", 64'(bus.dout), 64'(0));
        chk("midrst.ovf", 64'(bus.ovf), 64'(0));
        chk("midrst.shift", 64'(bus.shift_used), 64'(0));
        chk("midrst.sat", 64'(sat_count), 64'(0));
        rst = 1'b0;
        step();
        chk("postrst.flush", 64'(bus.dout_valid), 64'(0));
        drive(32'h0, 1'b0);
        step();
        chk_frame("postrst", 16'h7FFF, 4'hF, 5'd0);
        chk("postrst.sat", 64'(sat_count), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/corr_autoscale.md
CORR_AUTOSCALE -- requirements
Module: corr_autoscale

Interface
REQ-001 Parameter DIN_WIDTH, default 32, input word width per channel.
REQ-002 Parameter DIN_POINT, default 16, input fractional bits.
REQ-003 Parameter DOUT_WIDTH, default 16, output word width per channel.
REQ-004 Parameter DOUT_POINT, default 15, output fractional bits; DIN_POINT >= DOUT_POINT SHALL hold.
REQ-005 Parameter N_CH, default 4, number of parallel channels (e.g. r11, r22, r12_re, r12_im).
REQ-006 Parameter SHIFT_WIDTH, default 5, shift exponent width; MAXS = 2^SHIFT_WIDTH-1.
REQ-007 Parameter HOLD_FRAMES, default 4, consecutive frames required before the shift decrements.
REQ-008 clk  input  1  sole clock; all logic is on the rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 din  input  N_CH*DIN_WIDTH  signed channels, channel 0 in the LSBs.
REQ-011 din_valid  input  1  one frame (one correlation matrix) per asserted cycle.
REQ-012 auto_en  input  1  1 = automatic shift tracking, 0 = manual shift.
REQ-013 manual_shift  input  SHIFT_WIDTH  shift used while auto_en=0.
REQ-014 dout  output  N_CH*DOUT_WIDTH  signed scaled and saturated channels.
REQ-015 dout_valid  output  1  qualifies dout, shift_used and ovf.
REQ-016 shift_used  output  SHIFT_WIDTH  exponent applied to the frame on dout.
REQ-017 ovf  output  N_CH  per-channel saturation flag for the frame on dout.
REQ-018 sat_count  output  16  saturating count of frames with any ovf bit set.

Function
REQ-019 Each channel SHALL be computed as y = din >>> s (arithmetic), then repointed to DOUT_POINT by dropping the low DIN_POINT-DOUT_POINT bits (truncation toward -inf).
REQ-020 If y exceeds the DOUT_WIDTH signed range, the output SHALL saturate to the max/min code and the channel's ovf bit SHALL be 1; otherwise ovf=0.
REQ-021 Latency SHALL be exactly 2 cycles from din_valid to dout_valid, fully pipelined, accepting din_valid every cycle with no backpressure.
REQ-022 s for a frame SHALL be the value of the shift register c at the cycle din_valid is sampled; shift_used SHALL travel with that frame.
REQ-023 need(frame) SHALL be the smallest s in [0, MAXS] such that all channels fit without saturation, or MAXS if none; it is computed from the unshifted din via leading-sign detection.
REQ-024 Auto mode update, applied in the cycle after each valid frame: if need > c then c <= need and hold <= 0; if need == c then hold <= 0; if need < c then hold increments, and when HOLD_FRAMES consecutive such frames occur, c <= c-1 and hold <= 0.
REQ-025 The decrement SHALL be by exactly 1 per hold period and SHALL never go below 0.
REQ-026 The updated c SHALL take effect no later than the second din_valid after the triggering frame; back-to-back frames MAY still use the old c for exactly one frame.
REQ-027 With auto_en=0, c SHALL follow manual_shift every cycle and hold SHALL be 0.
REQ-028 On switching from auto_en=0 to 1, tracking SHALL start from the current manual_shift value.
REQ-029 Idle cycles (din_valid=0) SHALL neither advance hold nor change c.
REQ-030 sat_count SHALL increment by 1 per output frame with |ovf != 0 and hold at 16'hFFFF.

Reset
REQ-031 rst SHALL clear dout, ovf, shift_used, dout_valid, sat_count, c and hold to 0 on the next edge.
REQ-032 Frames in flight at reset SHALL be discarded, with no dout_valid for them.
REQ-033 rst SHALL take priority over din_valid in the same cycle.

Verification (defaults; all channels driven equal unless stated)
REQ-034 Manual shift 0, din=0x00008000 (0.5) -> 2 cycles later dout=0x4000 per channel, ovf=0, shift_used=0.
REQ-035 Auto, c=0, din=0x00020000 (2.0) -> dout=0x7FFF, ovf=4'hF, sat_count=1; next frame of 2.0 -> shift_used=2, dout=0x4000, ovf=0.
REQ-036 From c=2, din=0x00004000 (0.25) on consecutive frames -> c stays 2 for 3 frames; the frame after the 4th uses shift_used=1; 4 more frames bring it to 0; it never goes below 0.
REQ-037 Auto at c=2, alternating need=1 and need=2 frames -> hold resets each time and c stays 2; also din=-2.0 (0xFFFE0000) at c=0 -> dout=0x8000, ovf=1.
REQ-038 Continuous din_valid with rst pulsed mid-stream -> no dout_valid for the pre-reset frames, all outputs 0, and the first post-reset frame processed with shift 0.
